// File: rtl/div_seq.sv
// Sequential RV32M divider: DIV/DIVU/REM/REMU, restoring radix-2, one bit per clock.
// Ports: clk, rst_n, start, func3, rs1, rs2, flush -> busy, done, result.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOne = {XLEN{1'b1}};

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            sgn_q, sgn_d;
  logic            rop_q, rop_d;
  logic            nega_q, nega_d;
  logic            negb_q, negb_d;

  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div0, ovf;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   shf, trial;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  logic [XLEN-1:0] q_fix, r_fix, fin_res;

  // Operand preparation for the acceptance edge
  always_comb begin
    accept   = (state_q == S_IDLE) && start && func3[2] && !flush;
    a_neg    = ~func3[0] & rs1[XLEN-1];
    b_neg    = ~func3[0] & rs2[XLEN-1];
    a_abs    = a_neg ? (~rs1 + 1'b1) : rs1;
    b_abs    = b_neg ? (~rs2 + 1'b1) : rs2;
    div0     = (rs2 == '0);
    ovf      = ~func3[0] && (rs1 == MinNeg) && (rs2 == AllOne);
    fast_res = '0;
    if (div0) begin
      fast_res = func3[1] ? rs1 : AllOne;
    end else begin
      fast_res = func3[1] ? '0 : MinNeg;
    end
  end

  // One restoring step; bit XLEN of trial is the borrow
  always_comb begin
    shf     = {rem_q, quo_q[XLEN-1]};
    trial   = shf - {1'b0, dvs_q};
    ge      = ~trial[XLEN];
    rem_nxt = ge ? trial[XLEN-1:0] : shf[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
    // neg flags are already zero for unsigned ops
    q_fix   = (nega_q ^ negb_q) ? (~quo_nxt + 1'b1) : quo_nxt;
    r_fix   = nega_q ? (~rem_nxt + 1'b1) : rem_nxt;
    fin_res = rop_q ? r_fix : q_fix;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sgn_d   = sgn_q;
    rop_d   = rop_q;
    nega_d  = nega_q;
    negb_d  = negb_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sgn_d  = ~func3[0];
          rop_d  = func3[1];
          nega_d = a_neg;
          negb_d = b_neg;
          rem_d  = '0;
          quo_d  = a_abs;
          dvs_d  = b_abs;
          cnt_d  = '0;
          if (div0 || ovf) begin
            res_d   = fast_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = fin_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: back to idle, result keeps its last value
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      rop_q   <= 1'b0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      rop_q   <= rop_d;
      nega_q  <= nega_d;
      negb_q  <= negb_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq.
// Each task drives one scenario and checks inline.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_chk;
  int n_fail;

  div_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op and watch 40 cycles after acceptance edge.
  task automatic run_op(
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  bit          scramble,
    input  bit          pulse,
    output int          bc,
    output int          dc,
    output int          dat,
    output logic [31:0] res
  );
    bc  = 0;
    dc  = 0;
    dat = 0;
    @(negedge clk);
    res   = result;
    start = 1'b1;
    func3 = f;
    rs1   = a;
    rs2   = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc++;
        if (dat == 0) dat = i;
        res = result;
      end
      if (scramble) begin
        rs1   = $urandom;
        rs2   = $urandom;
        func3 = 3'($urandom_range(0, 7));
      end
      start = pulse && (i == 5 || i == 20 || i == 33);
      if (start) begin
        func3 = 3'd7;
        rs1   = 32'd55;
        rs2   = 32'd4;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'd0;
    rs1   = '0;
    rs2   = '0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  task automatic test_unsigned;
    int bc, dc, dat;
    logic [31:0] r;
    run_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_100_7: got %h want %h", r, 32'd14);
    end
    n_chk++;
    if (bc !== 32 || dc !== 1 || dat !== 33) begin
      n_fail++;
      $display("FAIL divu_timing: busy=%0d done=%0d at=%0d want 32 1 33",
               bc, dc, dat);
    end
    run_op(3'd7, 32'd100, 32'd7, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd2) begin
      n_fail++;
      $display("FAIL remu_100_7: got %h want %h", r, 32'd2);
    end
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'h7FFF_FFFC) begin
      n_fail++;
      $display("FAIL divu_big: got %h want 7ffffffc", r);
    end
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd1) begin
      n_fail++;
      $display("FAIL remu_big: got %h want 1", r);
    end
  endtask

  task automatic test_signed;
    int bc, dc, dat;
    logic [31:0] r;
    logic [2:0]  fv [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    fv = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
    av = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    bv = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
           32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'd1};
    ev = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
           32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    for (int k = 0; k < 8; k++) begin
      run_op(fv[k], av[k], bv[k], 1'b0, 1'b0, bc, dc, dat, r);
      n_chk++;
      if (r !== ev[k] || dc !== 1 || bc !== 32) begin
        n_fail++;
        $display("FAIL signed_%0d: f=%0d %h/%h got %h bc=%0d dc=%0d want %h 32 1",
                 k, fv[k], av[k], bv[k], r, bc, dc, ev[k]);
      end
    end
  endtask

  task automatic test_fast_path;
    int bc, dc, dat;
    logic [31:0] r;
    run_op(3'd4, 32'd5, 32'd0, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'hFFFF_FFFF || bc !== 0 || dc !== 1 || dat !== 1) begin
      n_fail++;
      $display("FAIL div_by_zero: r=%h bc=%0d dc=%0d at=%0d want ffffffff 0 1 1",
               r, bc, dc, dat);
    end
    run_op(3'd6, 32'd5, 32'd0, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd5 || bc !== 0 || dat !== 1) begin
      n_fail++;
      $display("FAIL rem_by_zero: r=%h bc=%0d at=%0d want 5 0 1", r, bc, dat);
    end
    run_op(3'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'h1234_5678 || dat !== 1) begin
      n_fail++;
      $display("FAIL remu_by_zero: r=%h at=%0d want 12345678 1", r, dat);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'h8000_0000 || bc !== 0 || dc !== 1 || dat !== 1) begin
      n_fail++;
      $display("FAIL div_ovf: r=%h bc=%0d dc=%0d at=%0d want 80000000 0 1 1",
               r, bc, dc, dat);
    end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd0 || bc !== 0 || dat !== 1) begin
      n_fail++;
      $display("FAIL rem_ovf: r=%h bc=%0d at=%0d want 0 0 1", r, bc, dat);
    end
  endtask

  task automatic test_ignore_nonmul;
    int bc, dc, dat;
    logic [31:0] r, prev;
    prev = result;
    run_op(3'd1, 32'd9, 32'd3, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (bc !== 0 || dc !== 0 || result !== prev) begin
      n_fail++;
      $display("FAIL ignore_func3: bc=%0d dc=%0d result=%h want 0 0 %h",
               bc, dc, result, prev);
    end
  endtask

  task automatic test_operand_hold;
    int bc, dc, dat;
    logic [31:0] r;
    run_op(3'd7, 32'd123456789, 32'd1000, 1'b1, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd789 || dc !== 1) begin
      n_fail++;
      $display("FAIL operand_hold: r=%h dc=%0d want %h 1", r, dc, 32'd789);
    end
  endtask

  task automatic test_start_in_calc;
    int bc, dc, dat;
    logic [31:0] r;
    run_op(3'd4, 32'd100, 32'd7, 1'b0, 1'b1, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd14 || dc !== 1 || bc !== 32) begin
      n_fail++;
      $display("FAIL start_in_calc: r=%h dc=%0d bc=%0d want e 1 32", r, dc, bc);
    end
  endtask

  task automatic test_flush;
    int bc, dc, dat;
    int seen;
    logic [31:0] r, prev;
    prev = result;
    @(negedge clk);
    start = 1'b1;
    func3 = 3'd5;
    rs1   = 32'd1000;
    rs2   = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_busy: busy=%b want 1", busy);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: busy=%b want 0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen !== 0 || result !== prev) begin
      n_fail++;
      $display("FAIL flush_no_done: dones=%0d result=%h want 0 %h",
               seen, result, prev);
    end
    run_op(3'd5, 32'd1000, 32'd3, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd333 || bc !== 32 || dc !== 1) begin
      n_fail++;
      $display("FAIL after_flush: r=%h bc=%0d dc=%0d want %h 32 1",
               r, bc, dc, 32'd333);
    end
    // flush and start together: start must lose
    prev = result;
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    func3 = 3'd4;
    rs1   = 32'd9;
    rs2   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    n_chk++;
    if (seen !== 0 || result !== prev) begin
      n_fail++;
      $display("FAIL flush_beats_start: activity=%0d result=%h want 0 %h",
               seen, result, prev);
    end
  endtask

  task automatic test_back_to_back;
    int bc, dc, dat;
    logic [31:0] r;
    run_op(3'd5, 32'd81, 32'd9, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd9) begin
      n_fail++;
      $display("FAIL b2b_first: r=%h want 9", r);
    end
    run_op(3'd7, 32'd82, 32'd9, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd1 || dat !== 33) begin
      n_fail++;
      $display("FAIL b2b_second: r=%h at=%0d want 1 33", r, dat);
    end
  endtask

  task automatic test_reset_mid;
    int bc, dc, dat;
    int seen;
    logic [31:0] r;
    @(negedge clk);
    start = 1'b1;
    func3 = 3'd5;
    rs1   = 32'd100;
    rs2   = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b result=%h want 0 0 0",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL idle_after_mid_reset: activity=%0d want 0", seen);
    end
    run_op(3'd5, 32'd100, 32'd7, 1'b0, 1'b0, bc, dc, dat, r);
    n_chk++;
    if (r !== 32'd14 || bc !== 32 || dc !== 1) begin
      n_fail++;
      $display("FAIL after_mid_reset: r=%h bc=%0d dc=%0d want e 32 1",
               r, bc, dc);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_fast_path();
    test_ignore_nonmul();
    test_operand_hold();
    test_start_in_calc();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have a parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-005 func3  input  3  RV32M op: 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1  input  32  dividend, from the same operand bus that feeds the ALU.
REQ-007 rs2  input  32  divisor.
REQ-008 flush  input  1  synchronous abort from pipeline control.
REQ-009 busy  output  1  high while in CALC; the EX stage stalls on it.
REQ-010 done  output  1  one-cycle pulse: result is valid and is written back alongside the ALU result.
REQ-011 result  output  32  quotient or remainder, registered.

Function
REQ-012 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 with func3[2]=1 SHALL be accepted at that edge (E0); start with func3[2]=0 SHALL be ignored.
REQ-014 On acceptance, the block SHALL latch op (signed = ~func3[0], rem = func3[1]), |rs1|, |rs2| (absolute values for signed ops, raw for unsigned) and both operand signs.
REQ-015 Fast path: if rs2=0, or if signed with rs1=0x80000000 and rs2=0xFFFFFFFF, the block SHALL load result at E0 and go to DONE.
REQ-016 Fast-path values SHALL be:
- divide by zero: quotient 0xFFFFFFFF, remainder rs1.
- signed overflow: quotient 0x80000000, remainder 0.
REQ-017 Normal path: E0 SHALL enter CALC with a 5-bit counter at 0.
REQ-018 Each CALC edge SHALL perform one restoring radix-2 step: shift the {rem, quo} pair left one bit, trial-subtract the divisor from a 33-bit partial remainder, and set the quotient bit to 1 if the result is non-negative, restoring otherwise.
REQ-019 On the 32nd CALC edge (E32), the block SHALL apply sign correction, load result, and enter DONE.
REQ-020 Signed sign correction SHALL be: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-021 done SHALL be high exactly while in DONE (one cycle); DONE SHALL return to IDLE on the next edge unconditionally.
REQ-022 Latency SHALL be: normal path, done high in the cycle after E32; fast path, done high in the cycle after E0.
REQ-023 busy SHALL be 1 only in CALC; start SHALL be ignored in CALC and DONE, with no queuing.
REQ-024 result SHALL hold its value until the next load; rs1, rs2 and func3 changes after E0 SHALL have no effect.
REQ-025 flush=1 SHALL force IDLE at the next edge from any state, suppress done, and leave result unchanged.
REQ-026 flush and start in the same IDLE cycle: flush SHALL win and start SHALL not be accepted.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, busy=0, done=0, result=0 and clear internal operand registers.
REQ-028 Reset asserted mid-CALC SHALL abandon the operation; after release the block SHALL sit in IDLE awaiting start.

Verification
REQ-029 DIVU rs1=100, rs2=7 -> busy for 32 cycles, done 1 cycle, result=14; REMU with the same operands -> result=2.
REQ-030 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFD; REM with the same operands -> result=0xFFFFFFFF.
REQ-031 DIV 5/0 -> done in the cycle after E0, busy never high, result=0xFFFFFFFF; REM 5/0 -> result=5.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> fast path, result=0x80000000; REM with the same operands -> result=0.
REQ-033 Start DIVU; assert flush at the 10th CALC cycle -> busy=0 next cycle, no done pulse, result keeps its previous value; the next start is accepted normally.
REQ-034 Drop rst_n mid-CALC, between clock edges -> busy, done and result read 0 before the next clk edge; start pulses during CALC are ignored (single done only).
